// File: rtl/mul_div_sequencer_pkg.sv
// Shared ALU definitions: ctrl encodings, sequencer state type, default width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for the two ctrl codes that the multi-cycle unit serves.
    function automatic logic is_mul_div(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/mul_div_sequencer_if.sv
// Handshake and operand/result bundle between the ALU control and the
// multi-cycle multiply/divide unit.
interface mul_div_sequencer_if #(
    parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] ZHI;
    logic [WIDTH-1:0] ZLO;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, ctrl, A, B,
        input  ZHI, ZLO, busy, done, div_zero
    );

    modport slave (
        input  start, ctrl, A, B,
        output ZHI, ZLO, busy, done, div_zero
    );
endinterface

// File: rtl/mul_div_sequencer_div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem, quo}
// left, trial-subtract the divisor and keep the difference when it fits.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic           fits;

    // Shifted remainder keeps one extra bit because the divisor magnitude can be 2^(WIDTH-1).
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = shifted >= {1'b0, divisor};
        rem_next = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end
endmodule

// File: rtl/mul_div_sequencer.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring on
// magnitudes with sign fix-up) beside the single-cycle ALU.
module mul_div_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    mul_div_sequencer_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t state;
    state_t next_state;

    logic [CW-1:0]    count;
    logic             op_div;
    logic             dz;
    logic             b_neg;
    logic             div_zero_q;
    logic             accept;
    logic             busy;
    logic             done;

    logic [WIDTH:0]   mcand;
    logic [WIDTH:0]   p_hi;
    logic [WIDTH-1:0] p_lo;
    logic             q_1;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   p_hi_n;
    logic [WIDTH-1:0] p_lo_n;
    logic             q_1_n;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] a_abs_in;
    logic [WIDTH-1:0] b_abs_in;

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] zhi_q;
    logic [WIDTH-1:0] zlo_q;

    assign accept   = (state == IDLE) && bus.start && is_mul_div(bus.ctrl);
    assign a_abs_in = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign b_abs_in = bus.B[WIDTH-1] ? -bus.B : bus.B;

    div_restore_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (b_abs),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= next_state;
    end

    // Next state: a divide by zero leaves RUN after one cycle, otherwise after WIDTH iterations.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (dz || (count == LAST)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // One Booth step: add/subtract on the widened upper half, then arithmetic shift.
    always_comb begin
        case ({p_lo[0], q_1})
            2'b01:   booth_sum = p_hi + mcand;
            2'b10:   booth_sum = p_hi - mcand;
            default: booth_sum = p_hi;
        endcase
        p_hi_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        p_lo_n = {booth_sum[0], p_lo[WIDTH-1:1]};
        q_1_n  = p_lo[0];
    end

    // Final result selection, including the divide sign fix-up (truncation toward zero).
    always_comb begin
        if (dz) begin
            res_hi = mcand[WIDTH-1:0];
            res_lo = '1;
        end else if (op_div) begin
            res_hi = mcand[WIDTH-1] ? -rem : rem;
            res_lo = (mcand[WIDTH-1] ^ b_neg) ? -quo : quo;
        end else begin
            res_hi = p_hi[WIDTH-1:0];
            res_lo = p_lo;
        end
    end

    // Operand capture, iteration and result registers; results move only on DONE entry.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count      <= '0;
            op_div     <= 1'b0;
            dz         <= 1'b0;
            b_neg      <= 1'b0;
            div_zero_q <= 1'b0;
            mcand      <= '0;
            p_hi       <= '0;
            p_lo       <= '0;
            q_1        <= 1'b0;
            rem        <= '0;
            quo        <= '0;
            b_abs      <= '0;
            zhi_q      <= '0;
            zlo_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_div     <= (bus.ctrl == ALU_DIV);
                        dz         <= (bus.ctrl == ALU_DIV) && (bus.B == '0);
                        div_zero_q <= (bus.ctrl == ALU_DIV) && (bus.B == '0);
                        b_neg      <= bus.B[WIDTH-1];
                        count      <= '0;
                        mcand      <= {bus.A[WIDTH-1], bus.A};
                        p_hi       <= '0;
                        p_lo       <= bus.B;
                        q_1        <= 1'b0;
                        rem        <= '0;
                        quo        <= a_abs_in;
                        b_abs      <= b_abs_in;
                    end
                end
                RUN: begin
                    if (next_state == DONE) begin
                        zhi_q <= res_hi;
                        zlo_q <= res_lo;
                    end else begin
                        count <= count + CW'(1);
                        p_hi  <= p_hi_n;
                        p_lo  <= p_lo_n;
                        q_1   <= q_1_n;
                        rem   <= rem_n;
                        quo   <= quo_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ZHI      = zhi_q;
    assign bus.ZLO      = zlo_q;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.div_zero = div_zero_q;
endmodule
